// File: rtl/tag_frame_arbiter.sv
// Frame-atomic round-robin mux of NUM_REQ AXI-stream sources: 1-cycle grant, 0-cycle beats, 1 idle gap per frame.
// m_axis_tready passes straight to the granted source only; TAG_ARB_MAX_BEATS_EN truncates frames at MAX_BEATS.
module tag_frame_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int NUM_TAGS   = 20,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_BEATS  = 16,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             s_axis_tvalid,
  output logic [NUM_REQ-1:0]             s_axis_tready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_REQ*NUM_TAGS-1:0]    s_axis_tuser,
  input  logic [NUM_REQ-1:0]             s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [NUM_TAGS-1:0]            m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic                           busy,
  output logic [GW-1:0]                  grant_idx,
  output logic [15:0]                    frame_cnt,
  output logic                           trunc_flag
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_q;
  logic [15:0]     frame_cnt_q;
  logic            busy_q;

  logic            pick_vld;
  logic [GW-1:0]   grant_d;
  logic [GW-1:0]   rr_d;
  logic            src_vld;
  logic            src_last;
  logic            beat_fire;
  logic            cap_hit;

  // First requester at or after rr_q: scan from the far end so the nearest offset wins.
  always_comb begin
    logic [GW-1:0] idx;
    pick_vld = 1'b0;
    grant_d  = '0;
    idx      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_q) + i) % NUM_REQ);
      if (s_axis_tvalid[idx]) begin
        pick_vld = 1'b1;
        grant_d  = idx;
      end
    end
  end

  assign rr_d      = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
  assign src_vld   = s_axis_tvalid[grant_q];
  assign src_last  = s_axis_tlast[grant_q];
  assign beat_fire = (state_q == ST_FWD) && src_vld && m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == ST_FWD) begin
      s_axis_tready[grant_q] = m_axis_tready;
    end else if (state_q == ST_DRAIN) begin
      s_axis_tready[grant_q] = 1'b1;
    end
  end

  assign m_axis_tvalid = (state_q == ST_FWD) && src_vld;
  assign m_axis_tdata  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign m_axis_tuser  = s_axis_tuser[int'(grant_q)*NUM_TAGS +: NUM_TAGS];
  assign m_axis_tlast  = src_last || ((state_q == ST_FWD) && cap_hit);

`ifdef TAG_ARB_MAX_BEATS_EN
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  logic [BW-1:0] beat_q;
  logic          trunc_q;

  assign cap_hit    = (beat_q == BW'(MAX_BEATS - 1));
  assign trunc_flag = trunc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      beat_q      <= '0;
      trunc_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q <= grant_d;
            beat_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_FWD;
          end
        end
        ST_FWD: begin
          if (beat_fire) begin
            if (m_axis_tlast) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
              // Forced last: the source still owes the tail of its frame, swallow it.
              if (!src_last) begin
                trunc_q <= 1'b1;
                state_q <= ST_DRAIN;
              end else begin
                rr_q    <= rr_d;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (src_vld && src_last) begin
            rr_q    <= rr_d;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
`else
  logic unused_cfg;

  assign cap_hit    = 1'b0;
  assign trunc_flag = 1'b0;
  assign unused_cfg = (MAX_BEATS > 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q <= grant_d;
            busy_q  <= 1'b1;
            state_q <= ST_FWD;
          end
        end
        ST_FWD: begin
          if (beat_fire && src_last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            rr_q        <= rr_d;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
`endif

  assign busy      = busy_q;
  assign grant_idx = grant_q;
  assign frame_cnt = frame_cnt_q;

endmodule
